tlb_ctrl: RTL and testbench
===========================

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising edge; resetn  input  1  asynchronous active-low reset.
REQ-002 SHALL have ports: req_valid  input  1  TLB instruction request; req_ready  output  1  request accepted when high with req_valid.
REQ-003 SHALL have ports: req_op  input  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5-7 illegal; req_inv_op  input  5  invtlb opcode; req_index  input  4  TLBIDX.index; req_vppn  input  19  search/invalidate VPPN; req_asid  input  10  search/invalidate ASID.
REQ-004 SHALL have ports: done  output  1  one-cycle completion pulse; resp_found  output  1  SRCH hit; resp_index  output  4  hit index (SRCH) or written index (WR/FILL); resp_err  output  1  illegal op.
REQ-005 SHALL have TLB-side ports: tlb_s_vppn  output  19; tlb_s_asid  output  10; tlb_s_found  input  1; tlb_s_index  input  4; tlb_we  output  1; tlb_w_index  output  4; tlb_r_index  output  4; tlb_inv_valid  output  1; tlb_inv_op  output  5.

Function
REQ-006 SHALL implement FSM states IDLE, EXEC, DONE; state encoding free.
REQ-007 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid && req_ready.
REQ-008 SHALL on acceptance latch op, inv_op, index, vppn, asid and go to EXEC next cycle.
REQ-009 SHALL spend exactly one cycle in EXEC, then one cycle in DONE, then return to IDLE; done=1 only in DONE; accept-to-done latency 2 cycles; back-to-back requests accepted every 3 cycles.
REQ-010 SHALL in EXEC for SRCH drive tlb_s_vppn/tlb_s_asid from latched values and capture tlb_s_found into resp_found, tlb_s_index into resp_index at end of EXEC.
REQ-011 SHALL in EXEC for RD drive tlb_r_index = latched index; resp_found=0, resp_index=latched index.
REQ-012 SHALL in EXEC for WR assert tlb_we for exactly one cycle with tlb_w_index = latched index.
REQ-013 SHALL maintain a 4-bit free-running fill counter, +1 every cycle out of reset, wrapping 15->0; FILL SHALL sample it at acceptance and use that value as tlb_w_index and resp_index.
REQ-014 SHALL in EXEC for INV with inv_op<=6 assert tlb_inv_valid one cycle, tlb_inv_op = latched inv_op, tlb_s_vppn/tlb_s_asid = latched values.
REQ-015 SHALL treat INV with inv_op>6 and req_op 5-7 as illegal: no tlb_we, no tlb_inv_valid, resp_err=1 in DONE.
REQ-016 SHALL keep tlb_we and tlb_inv_valid low outside EXEC; never both high same cycle.
REQ-017 SHALL hold resp_found/resp_index/resp_err stable from DONE until next acceptance; resp_err cleared on acceptance.
REQ-018 SHALL ignore req_valid outside IDLE; request fields need not be held after acceptance.
REQ-019 SHALL drive tlb_s_vppn/tlb_s_asid from the current req_vppn/req_asid while in IDLE (pass-through for lookahead).

Reset
REQ-020 SHALL on resetn=0 immediately go IDLE, fill counter=0, done=0, resp_found=0, resp_index=0, resp_err=0, tlb_we=0, tlb_inv_valid=0, tlb_inv_op=0, tlb_w_index=0, tlb_r_index=0.
REQ-021 SHALL abort any in-flight operation on reset mid-EXEC/DONE with no further TLB write, invalidate or done pulse; req_ready=1 first cycle after release.

Verification
REQ-022 SRCH vppn=0x12345 asid=0x05, TLB returns found=1 index=7 -> done at accept+2, resp_found=1, resp_index=7, no tlb_we.
REQ-023 WR index=3 -> tlb_we=1, tlb_w_index=3 exactly at accept+1; done at accept+2, resp_index=3.
REQ-024 FILL accepted 9 cycles after reset release -> tlb_w_index=9, resp_index=9; FILL at counter=15 -> 15, next cycle counter=0.
REQ-025 INV inv_op=5 -> tlb_inv_valid=1, tlb_inv_op=5 one cycle; INV inv_op=7 and req_op=6 -> no inv_valid/we, resp_err=1.
REQ-026 req_valid held high continuously -> accepts at cycles 0,3,6; req_ready=0 in EXEC/DONE.
REQ-027 resetn low during EXEC of WR -> tlb_we low immediately, no done pulse, all outputs at reset values.

Source files
------------

// File: rtl/tlb_ctrl_if.sv
// tlb_ctrl_if: request/response bundle between a TLB instruction issuer and tlb_ctrl
// Signals: req_valid/req_ready handshake, req_op/req_inv_op/req_index/req_vppn/req_asid
//   request fields, done/resp_found/resp_index/resp_err completion result.
// Modports: master = issuer, slave = tlb_ctrl.
interface tlb_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [3:0]  req_index;
  logic [18:0] req_vppn;
  logic [9:0]  req_asid;
  logic        done;
  logic        resp_found;
  logic [3:0]  resp_index;
  logic        resp_err;
  modport master (
    output req_valid, req_op, req_inv_op, req_index, req_vppn, req_asid,
    input  req_ready, done, resp_found, resp_index, resp_err
  );
  modport slave (
    input  req_valid, req_op, req_inv_op, req_index, req_vppn, req_asid,
    output req_ready, done, resp_found, resp_index, resp_err
  );
endinterface

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: sequences TLB search/read/write/fill/invalidate instructions (IDLE->EXEC->DONE)
// Ports: clk, resetn (async active-low); req = tlb_ctrl_if.slave request/response bundle;
//   tlb_s_* search port, tlb_we/tlb_w_index write port, tlb_r_index read port,
//   tlb_inv_valid/tlb_inv_op invalidate port.
module tlb_ctrl (
  input  logic        clk,
  input  logic        resetn,
  tlb_ctrl_if.slave   req,
  output logic [18:0] tlb_s_vppn,
  output logic [9:0]  tlb_s_asid,
  input  logic        tlb_s_found,
  input  logic [3:0]  tlb_s_index,
  output logic        tlb_we,
  output logic [3:0]  tlb_w_index,
  output logic [3:0]  tlb_r_index,
  output logic        tlb_inv_valid,
  output logic [4:0]  tlb_inv_op
);
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  inv_op_q;
  logic [3:0]  idx_q;
  logic [18:0] vppn_q;
  logic [9:0]  asid_q;
  logic        found_q;
  logic [3:0]  rindex_q;
  logic        err_q;
  logic        accept;
  logic        exec;
  logic        illegal;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    exec          = state_q == EXEC;
    accept        = req.req_valid && state_q == IDLE;
    illegal       = op_q > OP_INV || (op_q == OP_INV && inv_op_q > 5'd6);
    state_d       = state_q == IDLE ? (accept ? EXEC : IDLE) : state_q == EXEC ? DONE : IDLE;
    req.req_ready = state_q == IDLE;
    req.done      = state_q == DONE;
    tlb_we        = exec && !illegal && (op_q == OP_WR || op_q == OP_FILL);
    tlb_inv_valid = exec && !illegal && op_q == OP_INV;
    tlb_w_index   = idx_q;
    tlb_r_index   = idx_q;
    tlb_inv_op    = inv_op_q;
    tlb_s_vppn    = state_q == IDLE ? req.req_vppn : vppn_q;
    tlb_s_asid    = state_q == IDLE ? req.req_asid : asid_q;
  end
  // FILL takes the free-running counter value at acceptance as its index, so
  // the same register serves as write index for both WR and FILL.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      op_q     <= '0;
      inv_op_q <= '0;
      idx_q    <= '0;
      vppn_q   <= '0;
      asid_q   <= '0;
      found_q  <= 1'b0;
      rindex_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
      if (accept) begin
        op_q     <= req.req_op;
        inv_op_q <= req.req_inv_op;
        idx_q    <= req.req_op == OP_FILL ? cnt_q : req.req_index;
        vppn_q   <= req.req_vppn;
        asid_q   <= req.req_asid;
        err_q    <= 1'b0;
      end
      if (exec) begin
        found_q  <= !illegal && op_q == OP_SRCH && tlb_s_found;
        rindex_q <= op_q == OP_SRCH ? tlb_s_index : idx_q;
        err_q    <= illegal;
      end
    end
  end
  assign req.resp_found = found_q;
  assign req.resp_index = rindex_q;
  assign req.resp_err   = err_q;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed self-checking bench for tlb_ctrl with a response scoreboard
module tb_tlb_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [18:0] tlb_s_vppn;
  logic [9:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [3:0]  tlb_s_index;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [3:0]  tlb_r_index;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    logic       found;
    logic [3:0] index;
    logic       err;
    logic       chk_idx;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  tlb_ctrl_if bus();
  tlb_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .req          (bus.slave),
    .tlb_s_vppn   (tlb_s_vppn),
    .tlb_s_asid   (tlb_s_asid),
    .tlb_s_found  (tlb_s_found),
    .tlb_s_index  (tlb_s_index),
    .tlb_we       (tlb_we),
    .tlb_w_index  (tlb_w_index),
    .tlb_r_index  (tlb_r_index),
    .tlb_inv_valid(tlb_inv_valid),
    .tlb_inv_op   (tlb_inv_op)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] op, input logic [4:0] inv, input logic [3:0] idx,
                     input logic [18:0] vppn, input logic [9:0] asid,
                     input logic sfound, input logic [3:0] sidx, input logic [3:0] fillv);
    exp_t e, got;
    logic legal, exp_we, exp_inv;
    legal   = op <= 3'd4 && !(op == 3'd4 && inv > 5'd6);
    exp_we  = legal && (op == 3'd2 || op == 3'd3);
    exp_inv = legal && op == 3'd4;
    e.found   = op == 3'd0 && sfound;
    e.index   = op == 3'd0 ? sidx : op == 3'd3 ? fillv : idx;
    e.err     = !legal;
    e.chk_idx = op <= 3'd3;
    chk("ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_inv_op = inv;
    bus.req_index  = idx;
    bus.req_vppn   = vppn;
    bus.req_asid   = asid;
    tlb_s_found    = sfound;
    tlb_s_index    = sidx;
    #1;
    chk("s_vppn_passthru", tlb_s_vppn, vppn);
    chk("s_asid_passthru", tlb_s_asid, asid);
    sb.push_back(e);
    tick();
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'($urandom);
    bus.req_inv_op = 5'($urandom);
    bus.req_index  = 4'($urandom);
    bus.req_vppn   = 19'($urandom);
    bus.req_asid   = 10'($urandom);
    #1;
    chk("ready_exec", bus.req_ready, 0);
    chk("done_exec", bus.done, 0);
    chk("err_cleared", bus.resp_err, 0);
    chk("we_exec", tlb_we, exp_we);
    chk("inv_exec", tlb_inv_valid, exp_inv);
    if (exp_we) chk("w_index", tlb_w_index, e.index);
    if (exp_inv) chk("inv_op", tlb_inv_op, inv);
    if (op == 3'd0 || exp_inv) begin
      chk("s_vppn_latched", tlb_s_vppn, vppn);
      chk("s_asid_latched", tlb_s_asid, asid);
    end
    if (op == 3'd1) chk("r_index", tlb_r_index, idx);
    tick();
    chk("done_pulse", bus.done, 1);
    chk("we_done", tlb_we, 0);
    chk("inv_done", tlb_inv_valid, 0);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("resp_found", bus.resp_found, got.found);
      chk("resp_err", bus.resp_err, got.err);
      if (got.chk_idx) chk("resp_index", bus.resp_index, got.index);
    end
    tick();
    chk("done_low", bus.done, 0);
    chk("found_held", bus.resp_found, e.found);
    chk("err_held", bus.resp_err, e.err);
  endtask
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_inv_op = '0;
    bus.req_index  = '0;
    bus.req_vppn   = '0;
    bus.req_asid   = '0;
    tlb_s_found    = 1'b0;
    tlb_s_index    = '0;
    repeat (2) tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.resp_found, 0);
    chk("rst_index", bus.resp_index, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_we", tlb_we, 0);
    chk("rst_inv", tlb_inv_valid, 0);
    chk("rst_inv_op", tlb_inv_op, 0);
    chk("rst_w_index", tlb_w_index, 0);
    chk("rst_r_index", tlb_r_index, 0);
    resetn = 1'b1;
    tick();
    run(3'd0, 5'd0, 4'd0, 19'h12345, 10'h005, 1'b1, 4'd7, 4'd0);
    run(3'd0, 5'd0, 4'd0, 19'h0abcd, 10'h3ff, 1'b0, 4'd2, 4'd0);
    run(3'd1, 5'd0, 4'd11, 19'h00001, 10'h001, 1'b1, 4'd9, 4'd0);
    run(3'd2, 5'd0, 4'd3, 19'h7ffff, 10'h123, 1'b0, 4'd0, 4'd0);
    run(3'd4, 5'd5, 4'd1, 19'h55555, 10'h0aa, 1'b0, 4'd0, 4'd0);
    run(3'd4, 5'd7, 4'd1, 19'h2aaaa, 10'h155, 1'b0, 4'd0, 4'd0);
    run(3'd6, 5'd0, 4'd4, 19'h11111, 10'h011, 1'b0, 4'd0, 4'd0);
    run(3'd7, 5'd2, 4'd4, 19'h22222, 10'h022, 1'b0, 4'd0, 4'd0);
    run(3'd2, 5'd0, 4'd15, 19'h33333, 10'h033, 1'b0, 4'd0, 4'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_index = 4'd5;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", bus.req_ready, i % 3 == 0);
      chk("b2b_done", bus.done, i % 3 == 2);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("b2b_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.req_index = 4'd6;
    tick();
    bus.req_valid = 1'b0;
    chk("abort_we_before", tlb_we, 1);
    resetn = 1'b0;
    #1;
    chk("abort_we", tlb_we, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_found", bus.resp_found, 0);
    chk("abort_index", bus.resp_index, 0);
    chk("abort_err", bus.resp_err, 0);
    chk("abort_w_index", tlb_w_index, 0);
    chk("abort_r_index", tlb_r_index, 0);
    chk("abort_inv_op", tlb_inv_op, 0);
    tick();
    chk("abort_done2", bus.done, 0);
    chk("abort_we2", tlb_we, 0);
    resetn = 1'b1;
    chk("release_ready", bus.req_ready, 1);
    repeat (9) tick();
    chk("release_no_done", bus.done, 0);
    run(3'd3, 5'd0, 4'd0, 19'h0, 10'h0, 1'b0, 4'd0, 4'd9);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (15) tick();
    run(3'd3, 5'd0, 4'd0, 19'h0, 10'h0, 1'b0, 4'd0, 4'd15);
    run(3'd3, 5'd0, 4'd0, 19'h0, 10'h0, 1'b0, 4'd0, 4'd2);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
